// File: rtl/mem_port_arbiter.sv
// Merges fetch and load/store ports onto one memory port. Data wins unless MAX_D_STREAK data grants ran while a fetch waited.
// Latency: grant edge to strobes is 1 cycle. Requests are held until their resp pulse. A 1-cycle idle bubble follows each completion.
module mem_port_arbiter #(
   parameter int WIDTH        = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_read,
   input  logic [WIDTH-1:0] instr_mem_address,
   output logic             instr_mem_resp,
   output logic [WIDTH-1:0] instr_mem_rdata,
   input  logic             data_read,
   input  logic             data_write,
   input  logic [3:0]       data_mbe,
   input  logic [WIDTH-1:0] data_mem_address,
   input  logic [WIDTH-1:0] data_mem_wdata,
   output logic             data_mem_resp,
   output logic [WIDTH-1:0] data_mem_rdata,
   output logic             mem_read,
   output logic             mem_write,
   output logic [3:0]       mem_mbe,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_resp,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

   state_t           state_q;
   logic [3:0]       streak_q;
   logic [3:0]       streak_d;
   logic             mem_read_q;
   logic             mem_write_q;
   logic [3:0]       mem_mbe_q;
   logic [WIDTH-1:0] mem_address_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic             data_req;
   logic             data_win;

   assign data_req = data_read | data_write;
   assign data_win = data_req & (~instr_read | (streak_q < STREAK_LIMIT));

   // Streak only counts data grants that made a waiting fetch lose.
   always_comb begin
      streak_d = streak_q;
      if (state_q == IDLE) begin
         if (data_win) begin
            if (!instr_read)
               streak_d = 4'd0;
            else if (streak_q != 4'hF)
               streak_d = streak_q + 4'd1;
         end else if (instr_read) begin
            streak_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         streak_q      <= 4'd0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_mbe_q     <= 4'h0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
      end else begin
         streak_q <= streak_d;
         case (state_q)
            IDLE: begin
               if (data_win) begin
                  state_q       <= D_BUSY;
                  mem_write_q   <= data_write;
                  mem_read_q    <= ~data_write;
                  mem_mbe_q     <= data_write ? data_mbe : 4'hF;
                  mem_address_q <= data_mem_address;
                  mem_wdata_q   <= data_mem_wdata;
               end else if (instr_read) begin
                  state_q       <= I_BUSY;
                  mem_read_q    <= 1'b1;
                  mem_write_q   <= 1'b0;
                  mem_mbe_q     <= 4'hF;
                  mem_address_q <= instr_mem_address;
               end
            end
            I_BUSY, D_BUSY: begin
               if (mem_resp) begin
                  state_q     <= IDLE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_mbe_q   <= 4'h0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_mbe         = mem_mbe_q;
   assign mem_address     = mem_address_q;
   assign mem_wdata       = mem_wdata_q;
   assign instr_mem_resp  = mem_resp & (state_q == I_BUSY);
   assign data_mem_resp   = mem_resp & (state_q == D_BUSY);
   assign instr_mem_rdata = mem_rdata;
   assign data_mem_rdata  = mem_rdata;

endmodule
